// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, IF/ID bundle, NOP and PC checks.
// Imported by if_id_reg and instruction_fetch_unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

  // A PC is unusable if it is not word aligned or lies past imem.
  function automatic logic pc_bad(
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] limit
  );
    return (pc[1:0] != 2'b00) || (pc >= limit);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID output register with valid/ready handshake, load and flush.
// Ports: clk, reset (sync, active low), load_i, flush_i, data_i, ready_i, valid_o, data_o.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t data_i,
  input  logic   ready_i,
  output logic   valid_o,
  output if_id_t data_o
);

  logic   valid_q, valid_d;
  if_id_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      // Accepted word with nothing behind it: drain.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '{instr: RV_NOP, pc: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC / fetch stage: drives imem, registers the read word toward decode,
// takes execute redirects, halts on bad PCs, counts accepted instructions.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_cs,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;
  logic        load, flush;
  if_id_t      id_in, id_out;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    load       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (pc_bad(pc_q, LIMIT)) begin
          state_d    = FAULT;
          fault_pc_d = pc_q;
        end else begin
          load = !id_valid || id_ready;
          if (load) pc_d = pc_q + 32'd4;
        end
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase
    // Redirect beats sequential fetch and flushes the in-flight word.
    if (redirect_valid && state_q != IDLE) begin
      flush = 1'b1;
      load  = 1'b0;
      if (pc_bad(redirect_pc, LIMIT)) begin
        state_d    = FAULT;
        fault_pc_d = redirect_pc;
        pc_d       = pc_q;
      end else begin
        state_d = RUN;
        pc_d    = redirect_pc;
      end
    end
    if (id_valid && id_ready && !flush) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign id_in = '{instr: imem_rdata, pc: pc_q};

  if_id_reg u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .flush_i (flush),
    .data_i  (id_in),
    .ready_i (id_ready),
    .valid_o (id_valid),
    .data_o  (id_out)
  );

  assign imem_cs     = (state_q == RUN);
  assign imem_addr   = pc_q;
  assign id_instr    = id_out.instr;
  assign id_pc       = id_out.pc;
  assign fetch_fault = (state_q == FAULT);
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// imem model returns word index (addr>>2) as the instruction.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_cs;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {2'b00, imem_addr[31:2]};

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_cs        (imem_cs),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_valid"}, 32'(id_valid), 32'd0);
    chk({t, "_instr"}, id_instr, 32'h13);
    chk({t, "_idpc"}, id_pc, 32'h0);
    chk({t, "_fault"}, 32'(fetch_fault), 32'd0);
    chk({t, "_fpc"}, fault_pc, 32'h0);
    chk({t, "_cnt"}, fetch_count, 32'd0);
    chk({t, "_cs"}, 32'(imem_cs), 32'd0);
    chk({t, "_addr"}, imem_addr, 32'h0);
  endtask

  task automatic chk_id(input string t, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] cnt);
    chk({t, "_valid"}, 32'(id_valid), 32'(v));
    chk({t, "_instr"}, id_instr, ins);
    chk({t, "_idpc"}, id_pc, pc);
    chk({t, "_cnt"}, fetch_count, cnt);
  endtask

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;
    step();
    step();
    chk_reset("rst");

    // 1: streaming
    reset = 1'b1;
    step();
    chk("idle_cs", 32'(imem_cs), 32'd1);
    chk("idle_valid", 32'(id_valid), 32'd0);
    chk("idle_addr", imem_addr, 32'h0);
    step();
    chk_id("s0", 1'b1, 32'd0, 32'h0, 32'd0);
    chk("s0_addr", imem_addr, 32'h4);
    step();
    chk_id("s1", 1'b1, 32'd1, 32'h4, 32'd1);
    step();
    chk_id("s2", 1'b1, 32'd2, 32'h8, 32'd2);

    // 2: stall
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("stall", 1'b1, 32'd2, 32'h8, 32'd2);
      chk("stall_addr", imem_addr, 32'hC);
    end
    id_ready = 1'b1;
    step();
    chk_id("resume", 1'b1, 32'd3, 32'hC, 32'd3);

    // 3: good redirect flushes in-flight word
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(id_valid), 32'd0);
    chk("rd_cnt", fetch_count, 32'd3);
    chk("rd_addr", imem_addr, 32'h40);
    step();
    chk_id("rd0", 1'b1, 32'h10, 32'h40, 32'd3);
    step();
    chk_id("rd1", 1'b1, 32'h11, 32'h44, 32'd4);

    // 4: misaligned redirect faults, good redirect recovers
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_fpc", fault_pc, 32'h42);
    chk("mis_cs", 32'(imem_cs), 32'd0);
    chk("mis_valid", 32'(id_valid), 32'd0);
    chk("mis_cnt", fetch_count, 32'd4);
    chk("mis_addr", imem_addr, 32'h48);
    step();
    chk("mis_hold", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("rec_fault", 32'(fetch_fault), 32'd0);
    chk("rec_cs", 32'(imem_cs), 32'd1);
    chk("rec_addr", imem_addr, 32'h10);
    step();
    chk_id("rec0", 1'b1, 32'h4, 32'h10, 32'd4);

    // 5: last word then sequential overrun
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFC;
    step();
    redirect_valid = 1'b0;
    chk("top_valid", 32'(id_valid), 32'd0);
    step();
    chk_id("top0", 1'b1, 32'h3FF, 32'hFFC, 32'd4);
    chk("top_fault0", 32'(fetch_fault), 32'd0);
    step();
    chk("ovr_fault", 32'(fetch_fault), 32'd1);
    chk("ovr_fpc", fault_pc, 32'h1000);
    chk("ovr_cs", 32'(imem_cs), 32'd0);
    chk("ovr_valid", 32'(id_valid), 32'd0);
    chk("ovr_cnt", fetch_count, 32'd5);
    step();
    chk("ovr_hold", 32'(fetch_fault), 32'd1);

    // 6: reset wins over same-cycle redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    step();
    chk_id("pre0", 1'b1, 32'h8, 32'h20, 32'd5);
    step();
    chk_id("pre1", 1'b1, 32'h9, 32'h24, 32'd6);
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    chk_reset("rst2");

    // redirect during IDLE is ignored
    reset = 1'b1;
    step();
    chk("idle_rd_addr", imem_addr, 32'h0);
    chk("idle_rd_cs", 32'(imem_cs), 32'd1);
    redirect_valid = 1'b0;
    step();
    chk_id("post0", 1'b1, 32'd0, 32'h0, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
